// File: rtl/flappy_render.sv
// flappy_render -- 640x480@60 raster renderer for the flappy bird game.
//
// Scans a VGA raster from a 25 MHz pixel clock and paints sky, pipes and the
// bird from a per-frame snapshot of the game state. The snapshot is latched
// at the start of vertical blank so a frame never tears; frame_tick pulses in
// the first cycle that uses the fresh snapshot.
//
// Ports:
//   clk        pixel clock, one pixel per cycle
//   rst        synchronous active-high reset
//   bird_y     bird centre height (signed world units, 0 = bottom row)
//   x          scroll offset, 0..PIPE_GAP-1
//   seq        NUM_PIPES pipe gap centres (signed, 0 = no pipe)
//   state      0 idle, 1 running, 2 dead
//   hsync      horizontal sync, active low, registered
//   vsync      vertical sync, active low, registered
//   rgb        {R4,G4,B4}, zero outside the visible area, registered
//   frame_tick one-cycle pulse per frame, registered
//
// The raster geometry (active/front/sync/back for each axis) is exposed as
// parameters whose defaults give the standard 800x525 timing.

// Per-pipe hit test: is world point (col, hgt) inside the solid part of pipe
// IDX given the scroll offset and that pipe's gap centre?
module flappy_pipe_hit #(
    parameter int IDX        = 0,
    parameter int BIRD_COL   = 100,
    parameter int BIRD_SZ    = 15,
    parameter int PIPE_WIDTH = 60,
    parameter int PIPE_ALLOW = 45,
    parameter int PIPE_GAP   = 240
) (
    input  logic signed [31:0] col,
    input  logic signed [31:0] hgt,
    input  logic signed [31:0] scroll,
    input  logic signed [31:0] center,
    output logic               hit
);
    logic signed [31:0] left;
    logic               in_cols;
    logic               in_wall;

    // Edges that fall off either side of the screen need no special case:
    // the column compare simply never matches there.
    always_comb begin
        left    = BIRD_COL + BIRD_SZ + IDX * PIPE_GAP - scroll;
        in_cols = (col >= left) && (col <= left + PIPE_WIDTH - 1);
        in_wall = (hgt < center - PIPE_ALLOW) || (hgt >= center + PIPE_ALLOW);
        hit     = (center != 0) && in_cols && in_wall;
    end
endmodule

module flappy_render #(
    parameter int BIRD_SZ    = 15,
    parameter int PIPE_WIDTH = 60,
    parameter int PIPE_ALLOW = 45,
    parameter int PIPE_GAP   = 240,
    parameter int SKY        = 480,
    parameter int NUM_PIPES  = 5,
    parameter int BIRD_COL   = 100,
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [31:0]          bird_y,
    input  logic signed [31:0]          x,
    input  logic [NUM_PIPES-1:0][31:0]  seq,
    input  logic [31:0]                 state,
    output logic                        hsync,
    output logic                        vsync,
    output logic [11:0]                 rgb,
    output logic                        frame_tick
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SNAP = VW'(V_ACTIVE);

    localparam logic [11:0] C_SKY  = 12'h4CF;
    localparam logic [11:0] C_PIPE = 12'h0A0;
    localparam logic [11:0] C_BIRD = 12'hFF0;
    localparam logic [11:0] C_DEAD = 12'hF00;

    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;

    // Snapshot of the game state, only ever read by the pixel logic.
    logic signed [31:0]         sh_bird_y;
    logic signed [31:0]         sh_x;
    logic [NUM_PIPES-1:0][31:0] sh_seq;
    logic [31:0]                sh_state;

    logic                       snap;
    logic signed [31:0]         col;
    logic signed [31:0]         row;
    logic signed [31:0]         hgt;
    logic                       visible;
    logic                       bird_hit;
    logic [NUM_PIPES-1:0]       pipe_hit;
    logic                       hs_low;
    logic                       vs_low;
    logic [11:0]                pix;

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount <= '0;
            vcount <= '0;
        end else if (hcount == H_LAST) begin
            hcount <= '0;
            vcount <= (vcount == V_LAST) ? '0 : vcount + 1'b1;
        end else begin
            hcount <= hcount + 1'b1;
        end
    end

    // First pixel of vertical blank: the whole visible frame has been drawn.
    assign snap = (hcount == '0) && (vcount == V_SNAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_bird_y <= '0;
            sh_x      <= '0;
            sh_seq    <= '0;
            sh_state  <= '0;
        end else if (snap) begin
            sh_bird_y <= bird_y;
            sh_x      <= x;
            sh_seq    <= seq;
            sh_state  <= state;
        end
    end

    // ------------------------------------------------------------------
    // Pixel evaluation (current counters, shadow state)
    // ------------------------------------------------------------------
    assign col = {{(32 - HW){1'b0}}, hcount};
    assign row = {{(32 - VW){1'b0}}, vcount};
    assign hgt = SKY - 1 - row;

    genvar g;
    generate
        for (g = 0; g < NUM_PIPES; g++) begin : g_pipe
            flappy_pipe_hit #(
                .IDX        (g),
                .BIRD_COL   (BIRD_COL),
                .BIRD_SZ    (BIRD_SZ),
                .PIPE_WIDTH (PIPE_WIDTH),
                .PIPE_ALLOW (PIPE_ALLOW),
                .PIPE_GAP   (PIPE_GAP)
            ) u_hit (
                .col    (col),
                .hgt    (hgt),
                .scroll (sh_x),
                .center (sh_seq[g]),
                .hit    (pipe_hit[g])
            );
        end
    endgenerate

    always_comb begin
        visible  = (col < H_ACTIVE) && (row < V_ACTIVE);
        bird_hit = (col >= BIRD_COL - BIRD_SZ) && (col <= BIRD_COL + BIRD_SZ) &&
                   (hgt >= sh_bird_y - BIRD_SZ) && (hgt <= sh_bird_y + BIRD_SZ);
        hs_low   = (col >= H_ACTIVE + H_FRONT) && (col < H_ACTIVE + H_FRONT + H_SYNC);
        vs_low   = (row >= V_ACTIVE + V_FRONT) && (row < V_ACTIVE + V_FRONT + V_SYNC);

        pix = C_SKY;
        if (!visible)
            pix = 12'h000;
        else if (bird_hit)
            pix = (sh_state == 32'd2) ? C_DEAD : C_BIRD;
        else if (|pipe_hit)
            pix = C_PIPE;
    end

    // All outputs share one register stage so they stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync      <= 1'b1;
            vsync      <= 1'b1;
            rgb        <= 12'h000;
            frame_tick <= 1'b0;
        end else begin
            hsync      <= !hs_low;
            vsync      <= !vs_low;
            rgb        <= pix;
            frame_tick <= snap;
        end
    end
endmodule

// File: tb/tb_flappy_render.sv
// Testbench for flappy_render. A small-geometry instance carries the game
// checks; a default-geometry instance is checked against the standard 800-pixel
// line timing and the all-sky top of the first frame.
module tb_flappy_render;
    localparam int BS = 3, PW = 6, PA = 4, PG = 20, NP = 5, BC = 10;
    localparam int HA = 64, HF = 4, HSY = 8, HB = 4, HT = HA + HF + HSY + HB;
    localparam int VA = 48, VF = 2, VSY = 2, VB = 3, VT = VA + VF + VSY + VB;
    localparam int FRAME = HT * VT;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [31:0]   bird_y = '0;
    logic signed [31:0]   x = '0;
    logic [NP-1:0][31:0]  seq = '0;
    logic [31:0]          state = '0;
    logic                 hsync, vsync, frame_tick;
    logic [11:0]          rgb;
    logic                 d_hsync, d_vsync, d_frame_tick;
    logic [11:0]          d_rgb;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hs_low_cnt = 0;
    int vs_low_cnt = 0;

    // reference model state
    int mh = 0, mv = 0, ph = 0, pv = 0;
    int s_by = 0, s_x = 0, s_st = 0;
    int s_sq [NP];
    logic e_hs, e_vs, e_tick;
    logic [11:0] e_rgb;
    int dh = 0, dv = 0, dph = 0, dpv = 0;
    logic de_hs, de_vs;
    logic [11:0] de_rgb;

    flappy_render #(
        .BIRD_SZ(BS), .PIPE_WIDTH(PW), .PIPE_ALLOW(PA), .PIPE_GAP(PG), .SKY(VA),
        .NUM_PIPES(NP), .BIRD_COL(BC),
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB)
    ) dut (
        .clk(clk), .rst(rst), .bird_y(bird_y), .x(x), .seq(seq), .state(state),
        .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_tick(frame_tick)
    );

    flappy_render dut_def (
        .clk(clk), .rst(rst), .bird_y(bird_y), .x(x), .seq(seq), .state(state),
        .hsync(d_hsync), .vsync(d_vsync), .rgb(d_rgb), .frame_tick(d_frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s at (%0d,%0d) got=%0h exp=%0h", tag, ph, pv, got, exp);
        end
    endtask

    function automatic logic [11:0] ref_pix(int c, int r);
        int h;
        int left;
        h = VA - 1 - r;
        if (c >= BC - BS && c <= BC + BS && h >= s_by - BS && h <= s_by + BS)
            return (s_st == 2) ? 12'hF00 : 12'hFF0;
        for (int i = 0; i < NP; i++) begin
            left = BC + BS - s_x + i * PG;
            if (s_sq[i] != 0 && c >= left && c < left + PW &&
                (h < s_sq[i] - PA || h >= s_sq[i] + PA))
                return 12'h0A0;
        end
        return 12'h4CF;
    endfunction

    // One clock: update the model at the edge, compare every output at negedge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst) begin
            e_hs = 1'b1; e_vs = 1'b1; e_tick = 1'b0; e_rgb = 12'h000;
            mh = 0; mv = 0; ph = -1; pv = -1;
            s_by = 0; s_x = 0; s_st = 0;
            for (int i = 0; i < NP; i++) s_sq[i] = 0;
            de_hs = 1'b1; de_vs = 1'b1; de_rgb = 12'h000;
            dh = 0; dv = 0; dph = -1; dpv = -1;
        end else begin
            ph = mh; pv = mv;
            e_hs   = !(ph >= HA + HF && ph < HA + HF + HSY);
            e_vs   = !(pv >= VA + VF && pv < VA + VF + VSY);
            e_tick = (ph == 0 && pv == VA);
            e_rgb  = (ph < HA && pv < VA) ? ref_pix(ph, pv) : 12'h000;
            if (e_tick) begin
                s_by = bird_y; s_x = x; s_st = state;
                for (int i = 0; i < NP; i++) s_sq[i] = seq[i];
            end
            mh++;
            if (mh == HT) begin mh = 0; mv = (mv + 1) % VT; end
            // default geometry never reaches its first snapshot in this run,
            // and rows below 464 hold no part of the zero-snapshot bird
            dph = dh; dpv = dv;
            de_hs  = !(dph >= 656 && dph < 752);
            de_vs  = !(dpv >= 490 && dpv < 492);
            de_rgb = (dph < 640 && dpv < 464) ? 12'h4CF : 12'h000;
            dh++;
            if (dh == 800) begin dh = 0; dv++; end
        end
        @(negedge clk);
        if (!hsync) hs_low_cnt++;
        if (!vsync) vs_low_cnt++;
        chk("rgb", rgb, e_rgb);
        chk("hsync", hsync, e_hs);
        chk("vsync", vsync, e_vs);
        chk("frame_tick", frame_tick, e_tick);
        chk("def_hsync", d_hsync, de_hs);
        chk("def_vsync", d_vsync, de_vs);
        chk("def_rgb", d_rgb, de_rgb);
        chk("def_frame_tick", d_frame_tick, 1'b0);
    endtask

    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        do begin tick(); n++; end while (!frame_tick && n < 2 * FRAME + 10);
        chk(tag, frame_tick, 1'b1);
    endtask

    task automatic pix_chk(input string tag, input int c, input int r, input logic [11:0] exp);
        int n;
        n = 0;
        do begin tick(); n++; end while (!(ph == c && pv == r) && n < 2 * FRAME + 10);
        chk(tag, rgb, exp);
    endtask

    initial begin
        int t0, h0, v0;

        // reset and idle
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_rgb", rgb, 12'h000);
        chk("reset_hsync", hsync, 1'b1);
        rst = 1'b0;
        t0 = cyc;
        wait_tick("first_tick");
        chk("first_tick_latency", cyc - t0, VA * HT + 1);

        // frame period and sync geometry over one whole frame
        t0 = cyc; h0 = hs_low_cnt; v0 = vs_low_cnt;
        wait_tick("second_tick");
        chk("tick_period", cyc - t0, FRAME);
        chk("hsync_low_per_frame", hs_low_cnt - h0, HSY * VT);
        chk("vsync_low_per_frame", vs_low_cnt - v0, VSY * HT);

        // bird render
        bird_y = 20; seq = '0; state = 1;
        wait_tick("bird_tick");
        pix_chk("bird_above", 10, 23, 12'h4CF);
        pix_chk("bird_centre", 10, 27, 12'hFF0);
        pix_chk("bird_right", 14, 27, 12'h4CF);
        pix_chk("bird_bottom", 10, 30, 12'hFF0);
        pix_chk("bird_below", 10, 31, 12'h4CF);
        state = 2;
        wait_tick("dead_tick");
        pix_chk("bird_dead", 10, 27, 12'hF00);

        // pipe render: pipe 1 spans columns 33..38, gap h 20..27
        x = 0; seq = '0; seq[1] = 24; bird_y = 40; state = 1;
        wait_tick("pipe_tick");
        pix_chk("pipe_top", 33, 5, 12'h0A0);
        pix_chk("pipe_right_out", 39, 5, 12'h4CF);
        pix_chk("pipe_wall_edge", 33, 19, 12'h0A0);
        pix_chk("pipe_gap_edge", 33, 20, 12'h4CF);
        pix_chk("pipe_gap", 33, 23, 12'h4CF);

        // bird over pipe 0 (columns 8..13)
        x = 5; seq = '0; seq[0] = 40; bird_y = 20;
        wait_tick("prio_tick");
        pix_chk("prio_bird", 10, 27, 12'hFF0);
        pix_chk("prio_pipe_below", 10, 31, 12'h0A0);

        // snapshot stability
        x = 0; seq = '0; bird_y = 20; state = 1;
        wait_tick("snap_tick");
        pix_chk("snap_point", 0, 10, 12'h4CF);
        bird_y = 30;
        pix_chk("snap_old_empty", 10, 14, 12'h4CF);
        pix_chk("snap_old_bird", 10, 27, 12'hFF0);
        wait_tick("snap_next_tick");
        pix_chk("snap_new_bird", 10, 14, 12'hFF0);
        pix_chk("snap_new_empty", 10, 27, 12'h4CF);

        // mid-frame reset renders the zero snapshot
        pix_chk("pre_reset", 0, 30, 12'h4CF);
        rst = 1'b1;
        tick();
        chk("midrst_rgb", rgb, 12'h000);
        chk("midrst_vsync", vsync, 1'b1);
        rst = 1'b0;
        t0 = cyc;
        pix_chk("zero_snap_sky", 10, 43, 12'h4CF);
        pix_chk("zero_snap_bird_top", 10, 44, 12'hFF0);
        pix_chk("zero_snap_bird_last", 10, 47, 12'hFF0);
        wait_tick("midrst_tick");
        chk("midrst_tick_latency", cyc - t0, VA * HT + 1);

        // randomized inputs, changed at arbitrary points in the frame
        for (int r = 0; r < 24; r++) begin
            bird_y = $urandom_range(0, VA - 1);
            x      = $urandom_range(0, PG - 1);
            state  = $urandom_range(0, 2);
            for (int i = 0; i < NP; i++)
                seq[i] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(PA, VA - 1));
            repeat ($urandom_range(200, 800)) tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/flappy_render.md
# flappy_render

Raster renderer for the flappy bird game: reads the bird height, scroll offset, pipe-centre sequence and game state published by `game_state` and drives a 640x480@60 VGA port with colour and sync. It snapshots the game state once per frame at the start of vertical blank, so a frame never tears. It also emits a one-cycle `frame_tick` that the top level uses to pace game-state updates.

## Interface
Parameters:
- `BIRD_SZ`, 15: bird half-size in pixels.
- `PIPE_WIDTH`, 60: pipe width in pixels.
- `PIPE_ALLOW`, 45: half-height of the pipe gap.
- `PIPE_GAP`, 240: horizontal pitch between pipes.
- `SKY`, 480: world height; world height h maps to screen row 479-h.
- `NUM_PIPES`, 5: entries in `seq`.
- `BIRD_COL`, 100: screen column of the bird centre.

Ports:
- `clk`, input, 1: pixel clock, 25 MHz, one pixel per cycle.
- `rst`, input, 1: synchronous, active-high reset.
- `bird_y`, input, 32 signed: bird centre height.
- `x`, input, 32 signed: scroll offset, 0..PIPE_GAP-1.
- `seq`, input, seq_t (NUM_PIPES x 32 signed): pipe gap centres. 0 means no pipe.
- `state`, input, 32: 0 idle, 1 running, 2 dead.
- `hsync`, output, 1: active low.
- `vsync`, output, 1: active low.
- `rgb`, output, 12: {R4,G4,B4}, forced to 0 outside the visible area.
- `frame_tick`, output, 1: one-cycle pulse per frame.

## Operation
- Counters:
  - `hcount` runs 0..799 and wraps to 0.
  - `vcount` increments when `hcount` wraps, runs 0..524 and wraps to 0.
  - Visible area is h<640 and v<480.
- Sync:
  - `hsync` is low for hcount 656..751.
  - `vsync` is low for vcount 490..491.
- Snapshot:
  - On the edge where (hcount,vcount)==(0,480), latch `bird_y`, `x`, every `seq[i]` and `state` into shadow registers.
  - All pixel evaluation uses only the shadow registers. Input changes at any other time have no effect until the next snapshot.
- Pixel evaluation at visible (c,r), with height h = 479 - r. All arithmetic is 32-bit signed, with no wrap for any in-range input.
  - Bird: BIRD_COL-BIRD_SZ <= c <= BIRD_COL+BIRD_SZ and bird_y-BIRD_SZ <= h <= bird_y+BIRD_SZ.
  - Pipe i:
    - Left edge L_i = BIRD_COL + BIRD_SZ - x + i*PIPE_GAP.
    - Hit when seq[i] != 0, L_i <= c <= L_i+PIPE_WIDTH-1, and (h < seq[i]-PIPE_ALLOW or h >= seq[i]+PIPE_ALLOW).
    - Negative or >639 edges clip naturally; there is no special case.
  - Priority is bird > any pipe > sky.
- Colours:
  - Sky: 12'h4CF.
  - Pipe: 12'h0A0.
  - Bird: 12'hFF0, or 12'hF00 when the shadow state==2.
  - State 0 and state 1 render identically.

## Timing
- Latency:
  - `rgb`, `hsync`, `vsync` and `frame_tick` are all registered.
  - They reflect the counter value of the previous cycle and stay mutually aligned.
- `frame_tick`:
  - Goes high for exactly one cycle, the cycle after counters equal (0,480).
  - This is also the first cycle in which the new snapshot is in use.
  - Period is 420000 cycles.
- Line period is 800 cycles; frame period is 525 lines.
- Reset, at any time including mid-frame:
  - Next edge: hcount=0, vcount=0, hsync=1, vsync=1, rgb=0, frame_tick=0.
  - All shadow registers are cleared to 0.
  - Scanning restarts at the top-left pixel.
  - The first frame after reset renders the zero snapshot: no pipes, bird centred at h=0, so the bird's lower half is clipped off screen.
  - The snapshot is first taken when the counters reach (0,480).
- Pipe pixel hit and bird pixel hit in the same cycle: bird colour wins.

## Test plan
- Reset and idle:
  - Assert rst for 3 cycles, then release.
  - rgb=0, hsync=vsync=1 on the cycle after reset.
  - First frame_tick arrives 384001 cycles after release.
  - Subsequent frame_ticks every 420000 cycles.
- Sync geometry:
  - hsync low for exactly 96 cycles per 800-cycle line.
  - vsync low for exactly 1600 cycles per frame.
  - rgb=0 for every hcount>=640 and for every vcount>=480.
- Bird render:
  - Drive bird_y=200, seq all 0, state=1, and wait one frame_tick.
  - Pixel (100,279) is 12'hFF0.
  - Pixels (116,279) and (100,263) are 12'h4CF.
  - With state=2, pixel (100,279) is 12'hF00.
- Pipe render:
  - Drive x=0, seq[1]=240, other seq entries 0, bird_y=400.
  - Pipe 1 spans columns 355..414.
  - Pixel (355,100) is 12'h0A0, inside the pipe above the gap.
  - Pixel (355,239) is sky, inside the gap (h=240).
  - Pixel (415,100) is sky.
  - Pixel (355,194) is pipe (h=285); pixel (355,195) is sky (h=284).
- Snapshot stability:
  - Change bird_y from 200 to 300 at (hcount,vcount)=(0,100).
  - The rest of that frame still renders the bird at rows 264..294.
  - The next frame renders it at rows 164..194.
- Mid-frame reset:
  - Assert rst at vcount=300, then release.
  - Counters restart at (0,0).
  - No frame_tick until counters reach (0,480).
  - The zero snapshot renders the bird at rows 464..479 only.
